// File: rtl/addr_decode_pkg.sv
// Shared defaults and the entry record for the address decode table.
package addr_decode_pkg;

    localparam int unsigned DEF_ADDR_W       = 8;
    localparam int unsigned DEF_KEY_W        = 16;
    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_ENTRIES      = 4;
    localparam int unsigned DEF_DEFAULT_DATA = 0;
    localparam int unsigned DEF_STRICT       = 0;

    // Entry layout at the default widths; the table re-declares it at its own widths.
    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] key;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/addr_decode_prio.sv
// Lowest-index priority encoder over the per-entry match vector.
module addr_decode_prio #(
    parameter int unsigned ENTRIES = 4,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] match,
    output logic               hit_c,
    output logic [IDX_W-1:0]   idx_c
);

    // Scan from the top so the lowest matching index is written last and wins.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_c = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/addr_decode_table.sv
// Small programmable key/data decode table with a one-cycle registered lookup.
module addr_decode_table
    import addr_decode_pkg::*;
#(
    parameter int unsigned       ADDR_W       = DEF_ADDR_W,
    parameter int unsigned       KEY_W        = DEF_KEY_W,
    parameter int unsigned       DATA_W       = DEF_DATA_W,
    parameter int unsigned       ENTRIES      = DEF_ENTRIES,
    parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(DEF_DEFAULT_DATA),
    parameter int unsigned       STRICT       = DEF_STRICT,
    localparam int unsigned      IDX_W        = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [KEY_W-1:0]  wr_key,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_all,
    output logic              wr_err,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic [DATA_W-1:0] rsp_data
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] key;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t              table_q [ENTRIES];
    logic [ENTRIES-1:0] match_c;
    logic               hit_c;
    logic [IDX_W-1:0]   idx_c;
    logic [DATA_W-1:0]  hit_data_c;
    logic               key_ok_c;
    logic               idx_ok_c;
    logic               wr_ok_c;

    // Only valid entries take part in matching; stale keys are harmless.
    always_comb begin
        match_c = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            match_c[i] = table_q[i].valid && (table_q[i].key == lk_addr);
        end
    end

    addr_decode_prio #(
        .ENTRIES (ENTRIES)
    ) u_prio (
        .match (match_c),
        .hit_c (hit_c),
        .idx_c (idx_c)
    );

    always_comb begin
        hit_data_c = DEFAULT_DATA;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (hit_c && (idx_c == IDX_W'(i))) begin
                hit_data_c = table_q[i].data;
            end
        end
    end

    // Upper key bits only matter in strict mode; otherwise the key wraps.
    assign key_ok_c = (STRICT == 0) || ((wr_key >> ADDR_W) == '0);
    assign idx_ok_c = 32'(wr_idx) < ENTRIES;
    assign wr_ok_c  = wr_en && key_ok_c && idx_ok_c;

    // Lookup reads the pre-edge table, so same-cycle writes are not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i].valid <= 1'b0;
            end
            wr_err    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            rsp_data  <= DEFAULT_DATA;
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (clr_all) begin
                    table_q[i].valid <= 1'b0;
                end
                if (wr_ok_c && (wr_idx == IDX_W'(i))) begin
                    table_q[i].valid <= 1'b1;
                    table_q[i].key   <= wr_key[ADDR_W-1:0];
                    table_q[i].data  <= wr_data;
                end
            end
            wr_err    <= wr_en && !(key_ok_c && idx_ok_c);
            rsp_valid <= lk_valid;
            if (lk_valid) begin
                rsp_hit  <= hit_c;
                rsp_idx  <= hit_c ? idx_c : '0;
                rsp_data <= hit_data_c;
            end
        end
    end

endmodule

// File: tb/tb_addr_decode_table.sv
// Scoreboard bench for addr_decode_table across default, strict, 3-entry and wide builds.
module tb_addr_decode_table;

    typedef struct {
        logic        hit;
        logic [3:0]  idx;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        exp_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = '0;
    logic [15:0] wr_key = '0;
    logic [7:0]  wr_data = '0;
    logic        clr_all = 1'b0;
    logic        lk_valid = 1'b0;
    logic [7:0]  lk_addr = '0;

    logic        d_err, d_v, d_hit;
    logic [1:0]  d_idx;
    logic [7:0]  d_data;
    logic        s_err, s_v, s_hit;
    logic [1:0]  s_idx;
    logic [7:0]  s_data;
    logic        e_err, e_v, e_hit;
    logic [1:0]  e_idx;
    logic [7:0]  e_data;

    logic        w_wr_en = 1'b0;
    logic [3:0]  w_wr_idx = '0;
    logic [15:0] w_wr_key = '0;
    logic [31:0] w_wr_data = '0;
    logic        w_clr_all = 1'b0;
    logic        w_lk_valid = 1'b0;
    logic [15:0] w_lk_addr = '0;
    logic        w_err, w_v, w_hit;
    logic [3:0]  w_idx;
    logic [31:0] w_data;

    int   checks = 0;
    int   errors = 0;
    exp_t q_d[$];
    exp_t q_s[$];
    exp_t q_w[$];
    exp_t last_d, last_s, last_w;
    vec_t tv[3];

    always #5 clk = ~clk;

    addr_decode_table u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .clr_all(clr_all), .wr_err(d_err), .lk_valid(lk_valid),
        .lk_addr(lk_addr), .rsp_valid(d_v), .rsp_hit(d_hit), .rsp_idx(d_idx), .rsp_data(d_data)
    );

    addr_decode_table #(.STRICT(1)) u_strict (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .clr_all(clr_all), .wr_err(s_err), .lk_valid(lk_valid),
        .lk_addr(lk_addr), .rsp_valid(s_v), .rsp_hit(s_hit), .rsp_idx(s_idx), .rsp_data(s_data)
    );

    addr_decode_table #(.ENTRIES(3)) u_e3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .clr_all(clr_all), .wr_err(e_err), .lk_valid(lk_valid),
        .lk_addr(lk_addr), .rsp_valid(e_v), .rsp_hit(e_hit), .rsp_idx(e_idx), .rsp_data(e_data)
    );

    addr_decode_table #(.ADDR_W(16), .KEY_W(16), .DATA_W(32), .ENTRIES(16)) u_wide (
        .clk(clk), .rst(rst), .wr_en(w_wr_en), .wr_idx(w_wr_idx), .wr_key(w_wr_key),
        .wr_data(w_wr_data), .clr_all(w_clr_all), .wr_err(w_err), .lk_valid(w_lk_valid),
        .lk_addr(w_lk_addr), .rsp_valid(w_v), .rsp_hit(w_hit), .rsp_idx(w_idx), .rsp_data(w_data)
    );

    function automatic exp_t mk(input logic hit, input int idx, input logic [31:0] data);
        exp_t e;
        e.hit  = hit;
        e.idx  = 4'(idx);
        e.data = data;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_rsp(input string tag, input logic hit, input logic [3:0] idx,
                           input logic [31:0] data, input exp_t e);
        chk({tag, "_hit"}, 32'(hit), 32'(e.hit));
        chk({tag, "_idx"}, 32'(idx), 32'(e.idx));
        chk({tag, "_data"}, data, e.data);
    endtask

    task automatic write(input logic [1:0] idx, input logic [15:0] key, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_key  = key;
        wr_data = data;
    endtask

    task automatic lookup(input logic [7:0] a, input exp_t ed, input exp_t es);
        lk_valid = 1'b1;
        lk_addr  = a;
        if (!rst) begin
            q_d.push_back(ed);
            q_s.push_back(es);
        end
    endtask

    task automatic w_lookup(input logic [15:0] a, input exp_t e);
        w_lk_valid = 1'b1;
        w_lk_addr  = a;
        if (!rst) q_w.push_back(e);
    endtask

    // One clock: predict valid/err from the driven inputs, then score the outputs.
    task automatic step();
        logic ev, wv, was_rst, es_err, ee_err;
        exp_t e;
        ev      = lk_valid && !rst;
        wv      = w_lk_valid && !rst;
        was_rst = rst;
        es_err  = wr_en && !rst && (wr_key[15:8] != 8'h00);
        ee_err  = wr_en && !rst && (wr_idx == 2'd3);
        @(posedge clk);
        #1;
        if (was_rst) begin
            last_d = mk(1'b0, 0, 32'h0);
            last_s = mk(1'b0, 0, 32'h0);
            last_w = mk(1'b0, 0, 32'h0);
        end
        chk("d_valid", 32'(d_v), 32'(ev));
        chk("s_valid", 32'(s_v), 32'(ev));
        chk("w_valid", 32'(w_v), 32'(wv));
        chk("d_err", 32'(d_err), 32'(0));
        chk("s_err", 32'(s_err), 32'(es_err));
        chk("e3_err", 32'(e_err), 32'(ee_err));
        chk("w_err", 32'(w_err), 32'(0));
        if (d_v) begin
            if (q_d.size() == 0) chk("d_sb_empty", 32'(1), 32'(0));
            else begin e = q_d.pop_front(); cmp_rsp("d", d_hit, 4'(d_idx), 32'(d_data), e); last_d = e; end
        end else cmp_rsp("d_hold", d_hit, 4'(d_idx), 32'(d_data), last_d);
        if (s_v) begin
            if (q_s.size() == 0) chk("s_sb_empty", 32'(1), 32'(0));
            else begin e = q_s.pop_front(); cmp_rsp("s", s_hit, 4'(s_idx), 32'(s_data), e); last_s = e; end
        end else cmp_rsp("s_hold", s_hit, 4'(s_idx), 32'(s_data), last_s);
        if (w_v) begin
            if (q_w.size() == 0) chk("w_sb_empty", 32'(1), 32'(0));
            else begin e = q_w.pop_front(); cmp_rsp("w", w_hit, w_idx, w_data, e); last_w = e; end
        end
        wr_en      = 1'b0;
        clr_all    = 1'b0;
        lk_valid   = 1'b0;
        w_wr_en    = 1'b0;
        w_clr_all  = 1'b0;
        w_lk_valid = 1'b0;
    endtask

    initial begin
        exp_t miss;
        miss = mk(1'b0, 0, 32'h0);
        tv[0].addr = 8'h00; tv[0].exp = miss;
        tv[1].addr = 8'h11; tv[1].exp = mk(1'b1, 0, 32'h11);
        tv[2].addr = 8'h22; tv[2].exp = mk(1'b1, 1, 32'h22);

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Basic programming and back-to-back table lookups
        write(2'd0, 16'h0011, 8'h11); step();
        write(2'd1, 16'h0022, 8'h22); step();
        for (int i = 0; i < 3; i++) begin
            lookup(tv[i].addr, tv[i].exp, tv[i].exp);
            step();
        end
        step();

        // Out-of-range index only exists on the 3-entry build
        write(2'd3, 16'h0077, 8'h77); step();

        // Truncating vs strict key handling
        clr_all = 1'b1; step();
        write(2'd2, 16'h0111, 8'h55); step();
        lookup(8'h11, mk(1'b1, 2, 32'h55), miss); step();

        // Clear with write keeps only the written entry, then duplicate-key priority
        clr_all = 1'b1;
        write(2'd2, 16'h0011, 8'hAA); step();
        lookup(8'h11, mk(1'b1, 2, 32'hAA), mk(1'b1, 2, 32'hAA)); step();
        write(2'd0, 16'h0011, 8'h11); step();
        lookup(8'h11, mk(1'b1, 0, 32'h11), mk(1'b1, 0, 32'h11)); step();
        clr_all = 1'b1;
        lookup(8'h11, mk(1'b1, 0, 32'h11), mk(1'b1, 0, 32'h11)); step();
        lookup(8'h11, miss, miss); step();

        // Read-before-write on the same edge
        write(2'd0, 16'h0033, 8'h33);
        lookup(8'h33, miss, miss); step();
        lookup(8'h33, mk(1'b1, 0, 32'h33), mk(1'b1, 0, 32'h33)); step();

        // Reset in the middle of a lookup stream
        write(2'd1, 16'h0044, 8'h44); step();
        for (int i = 0; i < 8; i++) begin
            rst = (i == 4);
            if (i < 4) lookup(8'h44, mk(1'b1, 1, 32'h44), mk(1'b1, 1, 32'h44));
            else       lookup(8'h44, miss, miss);
            step();
        end
        rst = 1'b0;
        lookup(8'h33, miss, miss); step();

        // Wide build: fill every entry, read each back, then an absent key
        for (int i = 0; i < 16; i++) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = 4'(i);
            w_wr_key  = 16'hA000 + 16'(i * 257);
            w_wr_data = 32'hD00D_0000 + 32'(i);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            w_lookup(16'hA000 + 16'(i * 257), mk(1'b1, i, 32'hD00D_0000 + 32'(i)));
            step();
        end
        w_lookup(16'h1234, miss); step();
        step();

        chk("d_sb_drain", 32'(q_d.size()), 32'(0));
        chk("s_sb_drain", 32'(q_s.size()), 32'(0));
        chk("w_sb_drain", 32'(q_w.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
